pacman_anim_sequencer: RTL

//  Frame sequencer for Pac-Man sprite animation. Owns one shared prescaler that generates the animation tick.

---
 rtl/pacman_anim_sequencer_if.sv | 21 ++
 rtl/pacman_anim_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/pacman_anim_sequencer_if.sv
// Handshake bundle between game-state logic (master) and the Pac-Man animation sequencer (slave).
interface pacman_anim_sequencer_if;
  logic       moving;
  logic       freeze;
  logic       death_start;
  logic [3:0] frame_idx;
  logic       mouth_open;
  logic       death_active;
  logic       death_done;
  logic       tick;

  modport master (
    output moving, freeze, death_start,
    input  frame_idx, mouth_open, death_active, death_done, tick
  );

  modport slave (
    input  moving, freeze, death_start,
    output frame_idx, mouth_open, death_active, death_done, tick
  );
endinterface

// File: rtl/pacman_anim_sequencer.sv
// Pac-Man sprite frame sequencer: shared tick prescaler, chomp cycle while moving, one-shot death sequence.
module pacman_anim_sequencer #(
  parameter int TICK_DIV     = 3125000,
  parameter int DEATH_FRAMES = 11
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pacman_anim_sequencer_if.slave  anim_if
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [3:0]    DEATH_LAST = 4'(2 + DEATH_FRAMES);

  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $error("pacman_anim_sequencer: TICK_DIV must be >= 2");
    end
    if (3 + DEATH_FRAMES > 16) begin : g_bad_frames
      $error("pacman_anim_sequencer: 3+DEATH_FRAMES must be <= 16");
    end
  endgenerate

  typedef enum logic [1:0] {RUN, DEATH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    frame_q, frame_d;
  logic          mouth_q, active_q, active_d, done_q, done_d, tick_q;
  logic          tick_w;

  // Chomp pose for each phase: closed, half, open, half.
  function automatic logic [3:0] chomp_frame(input logic [1:0] p);
    case (p)
      2'd0:    return 4'd0;
      2'd2:    return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  assign tick_w = (cnt_q == CNT_LAST) && !anim_if.freeze;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    frame_d  = frame_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (tick_w)
      cnt_d = '0;
    else if (anim_if.freeze)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);

    case (state_q)
      RUN: begin
        if (anim_if.death_start) begin
          // Restarting the prescaler gives the first death frame a full period.
          state_d  = DEATH;
          frame_d  = 4'd3;
          active_d = 1'b1;
          cnt_d    = '0;
        end else if (tick_w && anim_if.moving) begin
          phase_d = phase_q + 2'd1;
          frame_d = chomp_frame(phase_q + 2'd1);
        end
      end
      DEATH: begin
        if (tick_w) begin
          if (frame_q == DEATH_LAST) begin
            state_d  = DONE;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        phase_d = 2'd0;
        frame_d = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      frame_q  <= 4'd0;
      mouth_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      frame_q  <= frame_d;
      mouth_q  <= (frame_d != 4'd0);
      active_q <= active_d;
      done_q   <= done_d;
      tick_q   <= tick_w;
    end
  end

  assign anim_if.frame_idx    = frame_q;
  assign anim_if.mouth_open   = mouth_q;
  assign anim_if.death_active = active_q;
  assign anim_if.death_done   = done_q;
  assign anim_if.tick         = tick_q;

endmodule
